pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control FSM that sequences the 15-bit program counter block through its re/we/inc strobes.
- Runs a fetch handshake with instruction memory and applies decode-stage control-flow outcomes: sequential, jump, call, return.
- Owns a small return-address stack.
- Sits between the decoder, instruction memory port and the PC register.

Parameters:
AW, 15, address width; matches PC width
RESET_ADDR, 15'h0000, first fetch address after start
STACK_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  begin execution from RESET_ADDR (honoured in IDLE and HALT)
halt_req  in  1  stop after current instruction; sampled in DECODE
fetch_req  out  1  instruction fetch request to memory
fetch_ack  in  1  memory has returned the instruction
br_type  in  2  decode result: 00 seq, 01 jump, 10 call, 11 ret; sampled in DECODE
br_target  in  AW  jump/call target; sampled in DECODE
pc_cur  in  AW  PC block output (current fetch address)
pc_re  out  1  PC load strobe (store <= pc_in)
pc_we  out  1  PC publish strobe (out <= store)
pc_inc  out  1  PC increment strobe
pc_in  out  AW  PC load value
halted  out  1  high in HALT
stack_err  out  1  sticky overflow/underflow flag
busy  out  1  high in any state other than IDLE and HALT

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0; stack pointer 0.
  - Stack contents are don't-care; stack_err cleared.
  - Reset in any state, including mid-fetch, aborts immediately. fetch_req drops the next cycle.
- States: IDLE, LOAD, PUBLISH, FETCH, DECODE, HALT.
- IDLE: start -> LOAD.
- LOAD: pc_in=RESET_ADDR, pc_re=1 for one cycle -> PUBLISH.
- PUBLISH: pc_we=1 for one cycle -> FETCH. pc_cur holds the new address from the first FETCH cycle.
- FETCH: fetch_req=1, held until fetch_ack=1. On ack -> DECODE, with fetch_req low in DECODE.
- DECODE: exactly one cycle. Priority is halt_req > br_type.
  - halt_req=1 -> HALT; no PC strobe.
  - seq: pc_inc=1 -> PUBLISH.
  - jump: pc_in=br_target, pc_re=1 -> PUBLISH.
  - call:
    - If stack full: set stack_err -> HALT.
    - Else: push pc_cur+1 (mod 2^AW), pc_in=br_target, pc_re=1 -> PUBLISH.
  - ret:
    - If stack empty: set stack_err -> HALT.
    - Else: pop; pc_in=popped value, pc_re=1 -> PUBLISH.
- Strobe exclusivity:
  - pc_re and pc_inc are never high in the same cycle.
  - pc_we is never high in the same cycle as pc_re or pc_inc.
- Steady-state cost per sequential instruction: DECODE + PUBLISH + FETCH cycles. Minimum 3 cycles with fetch_ack returned in the first FETCH cycle.
- Address arithmetic: unsigned AW bits, wraps silently (0x7FFF+1 = 0x0000). Wrap is not an error.
- Stack:
  - LIFO, depth STACK_DEPTH.
  - Full = STACK_DEPTH entries held; empty = 0 entries.
  - A faulting call or ret leaves the stack unchanged.
- HALT: halted=1, busy=0, no strobes.
  - start -> LOAD. The stack is cleared; stack_err is kept until rst.
  - start in any state other than IDLE/HALT is ignored.
- stack_err is cleared only by rst.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined:
  - Adds output retired_cnt [31:0], reset 0.
  - Increments by 1 on every DECODE cycle that does not go to HALT.
  - Saturates at 32'hFFFF_FFFF; cleared by rst only.
- Undefined: port absent, no counter logic.

Test Plan:
- rst, then start, fetch_ack returned 1 cycle after each fetch_req, br_type=00 ×3 -> pc_re then pc_we in the first two cycles; pc_cur sequence 0x0000, 0x0001, 0x0002, 0x0003; one pc_inc per instruction, never with pc_re.
- fetch_ack withheld 5 cycles -> fetch_req held high 5+ cycles, no PC strobes meanwhile; DECODE follows the ack cycle.
- Call at pc_cur=0x0010 to 0x0100, then ret -> pc_cur 0x0100, then 0x0011; stack empty after.
- Five nested calls with STACK_DEPTH=4 -> 5th call sets stack_err=1 and halted=1; pc_cur stays at the caller. ret from a fresh start with empty stack -> stack_err=1, HALT.
- Jump to 0x7FFF then seq -> pc_cur 0x7FFF then 0x0000, stack_err=0. halt_req together with br_type=01 in DECODE -> HALT, no pc_re. start from HALT -> restart at RESET_ADDR.
- rst asserted during FETCH with fetch_req high -> all outputs 0 next cycle, state IDLE. With PC_SEQ_PERF_EN, retired_cnt=0 after rst and equals the non-halting DECODE count otherwise.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC control FSM: fetch handshake, jump/call/ret, return-address stack.
// Optional retired-instruction counter enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer #(
    parameter int            AW          = 15,
    parameter logic [AW-1:0] RESET_ADDR  = '0,
    parameter int            STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          halt_req,
    output logic          fetch_req,
    input  logic          fetch_ack,
    input  logic [1:0]    br_type,
    input  logic [AW-1:0] br_target,
    input  logic [AW-1:0] pc_cur,
    output logic          pc_re,
    output logic          pc_we,
    output logic          pc_inc,
    output logic [AW-1:0] pc_in,
    output logic          halted,
    output logic          stack_err,
    output logic          busy
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]   retired_cnt
`endif
);

    localparam int IW  = $clog2(STACK_DEPTH);
    localparam int SPW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PUBLISH, S_FETCH, S_DECODE, S_HALT
    } state_t;

    state_t         state, state_nx;
    logic [AW-1:0]  stack_mem [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic [IW-1:0]  top_idx;
    logic           full, empty;
    logic           do_push, do_pop, fault;

    assign full    = (sp == SPW'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = sp[IW-1:0] - IW'(1);

    // Stack effects of the current DECODE; a faulting call/ret touches nothing.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        fault   = 1'b0;
        if (state == S_DECODE && !halt_req) begin
            case (br_type)
                2'b10: if (full) fault = 1'b1; else do_push = 1'b1;
                2'b11: if (empty) fault = 1'b1; else do_pop = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_LOAD;
            S_LOAD:    state_nx = S_PUBLISH;
            S_PUBLISH: state_nx = S_FETCH;
            S_FETCH:   if (fetch_ack) state_nx = S_DECODE;
            S_DECODE:  state_nx = (halt_req || fault) ? S_HALT : S_PUBLISH;
            S_HALT:    if (start) state_nx = S_LOAD;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_req = 1'b0;
        pc_re     = 1'b0;
        pc_we     = 1'b0;
        pc_inc    = 1'b0;
        pc_in     = '0;
        halted    = 1'b0;
        busy      = (state != S_IDLE) && (state != S_HALT);
        case (state)
            S_LOAD: begin
                pc_re = 1'b1;
                pc_in = RESET_ADDR;
            end
            S_PUBLISH: pc_we = 1'b1;
            S_FETCH:   fetch_req = 1'b1;
            S_DECODE: begin
                if (!halt_req) begin
                    case (br_type)
                        2'b00: pc_inc = 1'b1;
                        2'b01: begin
                            pc_re = 1'b1;
                            pc_in = br_target;
                        end
                        2'b10: begin
                            pc_re = do_push;
                            pc_in = do_push ? br_target : '0;
                        end
                        default: begin
                            pc_re = do_pop;
                            pc_in = do_pop ? stack_mem[top_idx] : '0;
                        end
                    endcase
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Restart from HALT empties the stack; stack_err survives until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            if (fault) stack_err <= 1'b1;
            if (state == S_HALT && start) sp <= '0;
            else if (do_push)             sp <= sp + SPW'(1);
            else if (do_pop)              sp <= sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) stack_mem[sp[IW-1:0]] <= pc_cur + AW'(1);
    end

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            retired_cnt <= '0;
        else if (state == S_DECODE && !halt_req && !fault && retired_cnt != 32'hFFFF_FFFF)
            retired_cnt <= retired_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed table, corner sequences and random run against a queue-based model.
module tb_pc_sequencer;
    localparam int AW    = 15;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, start, halt_req, fetch_req, fetch_ack;
    logic [1:0]    br_type;
    logic [AW-1:0] br_target, pc_cur, pc_in, pc_store;
    logic          pc_re, pc_we, pc_inc, halted, stack_err, busy;
`ifdef PC_SEQ_PERF_EN
    logic [31:0]   retired_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.AW(AW), .RESET_ADDR(15'h0000), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .br_type(br_type), .br_target(br_target), .pc_cur(pc_cur),
        .pc_re(pc_re), .pc_we(pc_we), .pc_inc(pc_inc), .pc_in(pc_in),
        .halted(halted), .stack_err(stack_err), .busy(busy)
`ifdef PC_SEQ_PERF_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    // PC block: store loads/increments, out publishes store.
    always @(posedge clk) begin
        if (rst) begin
            pc_store <= '0;
            pc_cur   <= '0;
        end else begin
            if (pc_re)       pc_store <= pc_in;
            else if (pc_inc) pc_store <= pc_store + 1'b1;
            if (pc_we)       pc_cur   <= pc_store;
        end
    end

    // Reference model state.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_err;
    int            m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ((pc_re && pc_inc) || (pc_we && (pc_re || pc_inc))) begin
                bad++;
                $display("FAIL strobe_excl: re=%0b we=%0b inc=%0b", pc_re, pc_we, pc_inc);
            end
        end
    end

    task automatic chk_perf();
`ifdef PC_SEQ_PERF_EN
        chk("retired_cnt", retired_cnt, m_ret);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; fetch_ack = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {fetch_req, pc_re, pc_we, pc_inc, halted, stack_err, busy}, 7'b0);
        chk("rst_pc_in", pc_in, 0);
        m_err = 1'b0; m_ret = 0; m_stk.delete(); m_pc = '0;
        chk_perf();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_strobes", {pc_re, pc_we, pc_inc, busy, halted}, 5'b10010);
        chk("load_pc_in", pc_in, 0);
        @(negedge clk);
        chk("publish_strobes", {pc_re, pc_we, pc_inc, fetch_req}, 4'b0100);
        m_pc = '0;
        m_stk.delete();
    endtask

    task automatic instr(input logic h, input logic [1:0] bt, input logic [AW-1:0] tgt, input int dly,
                         output logic [AW-1:0] fpc, output logic saw_re, output logic saw_inc,
                         output logic went_halt);
        int            n;
        logic          exp_re, exp_inc, exp_halt;
        logic [AW-1:0] exp_in;
        fpc = '0; saw_re = 1'b0; saw_inc = 1'b0; went_halt = 1'b0;
        n = 0;
        while (!fetch_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_seen", fetch_req, 1);
        if (!fetch_req) return;
        fpc = pc_cur;
        chk("fetch_pc", pc_cur, m_pc);
        for (int i = 0; i < dly; i++) begin
            chk("fetch_hold", {fetch_req, pc_re, pc_we, pc_inc}, 4'b1000);
            @(negedge clk);
        end
        fetch_ack = 1'b1; halt_req = h; br_type = bt; br_target = tgt;
        @(negedge clk);
        fetch_ack = 1'b0;
        chk("decode_fetch_req", {fetch_req, pc_we, busy}, 3'b001);

        exp_re = 1'b0; exp_inc = 1'b0; exp_halt = 1'b0; exp_in = '0;
        if (h) exp_halt = 1'b1;
        else begin
            case (bt)
                2'b00: begin exp_inc = 1'b1; m_pc = m_pc + 1'b1; end
                2'b01: begin exp_re = 1'b1; exp_in = tgt; m_pc = tgt; end
                2'b10: begin
                    if (m_stk.size() == DEPTH) begin exp_halt = 1'b1; m_err = 1'b1; end
                    else begin
                        m_stk.push_back(m_pc + 1'b1);
                        exp_re = 1'b1; exp_in = tgt; m_pc = tgt;
                    end
                end
                default: begin
                    if (m_stk.size() == 0) begin exp_halt = 1'b1; m_err = 1'b1; end
                    else begin
                        exp_in = m_stk.pop_back();
                        exp_re = 1'b1; m_pc = exp_in;
                    end
                end
            endcase
        end
        chk("decode_re", pc_re, exp_re);
        chk("decode_inc", pc_inc, exp_inc);
        if (exp_re) chk("decode_pc_in", pc_in, exp_in);
        saw_re = pc_re; saw_inc = pc_inc;
        if (!exp_halt) m_ret++;
        @(negedge clk);
        halt_req = 1'b0; br_type = 2'b00;
        if (exp_halt)
            chk("after_halt", {halted, busy, pc_re, pc_we, pc_inc, fetch_req}, 6'b100000);
        else
            chk("after_publish", {halted, busy, pc_re, pc_we, pc_inc}, 5'b01010);
        chk("stack_err", stack_err, m_err);
        chk_perf();
        went_halt = halted;
    endtask

    typedef struct {
        logic          h;
        logic [1:0]    bt;
        logic [AW-1:0] tgt;
        int            dly;
        logic [AW-1:0] fpc;
        logic          re;
        logic          inc;
        logic          hlt;
    } vec_t;

    vec_t          tbl[9];
    logic [AW-1:0] o_fpc;
    logic          o_re, o_inc, o_hlt;

    initial begin
        tbl[0] = '{1'b0, 2'b00, 15'h0000, 1, 15'h0000, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 2'b00, 15'h0000, 1, 15'h0001, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 2'b00, 15'h0000, 5, 15'h0002, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 2'b01, 15'h0010, 0, 15'h0003, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 2'b10, 15'h0100, 0, 15'h0010, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 2'b11, 15'h0000, 0, 15'h0100, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 2'b01, 15'h7FFF, 0, 15'h0011, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 2'b00, 15'h0000, 0, 15'h7FFF, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 2'b01, 15'h1234, 0, 15'h0000, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; halt_req = 1'b0; fetch_ack = 1'b0;
        br_type = 2'b00; br_target = '0;
        m_pc = '0; m_err = 1'b0; m_ret = 0;
        repeat (2) @(negedge clk);
        do_reset();

        do_start();
        for (int i = 0; i < 9; i++) begin
            instr(tbl[i].h, tbl[i].bt, tbl[i].tgt, tbl[i].dly, o_fpc, o_re, o_inc, o_hlt);
            chk($sformatf("tbl%0d_fpc", i), o_fpc, tbl[i].fpc);
            chk($sformatf("tbl%0d_re", i), o_re, tbl[i].re);
            chk($sformatf("tbl%0d_inc", i), o_inc, tbl[i].inc);
            chk($sformatf("tbl%0d_halt", i), o_hlt, tbl[i].hlt);
        end
        chk("tbl_stack_err", stack_err, 0);

        // Restart from HALT, then overflow the stack with a fifth call.
        do_start();
        for (int i = 1; i <= 5; i++)
            instr(1'b0, 2'b10, 15'(i * 32), 0, o_fpc, o_re, o_inc, o_hlt);
        chk("ovf_halt", o_hlt, 1);
        chk("ovf_err", stack_err, 1);
        repeat (3) @(negedge clk);
        chk("ovf_pc_cur", pc_cur, 15'h0080);
        chk("ovf_still_halted", halted, 1);

        // Restart empties the stack but keeps stack_err.
        do_start();
        chk("restart_err_kept", stack_err, 1);
        instr(1'b0, 2'b11, 15'h0000, 0, o_fpc, o_re, o_inc, o_hlt);
        chk("restart_ret_halt", o_hlt, 1);

        do_reset();
        do_start();
        instr(1'b0, 2'b11, 15'h0000, 1, o_fpc, o_re, o_inc, o_hlt);
        chk("udf_halt", o_hlt, 1);
        chk("udf_err", stack_err, 1);

        // Reset in the middle of a fetch.
        do_reset();
        do_start();
        @(negedge clk);
        chk("midfetch_req", fetch_req, 1);
        do_reset();

        do_start();
        o_hlt = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_hlt) do_start();
            instr(($urandom % 16) == 0, 2'($urandom % 4), 15'($urandom), int'($urandom % 3),
                  o_fpc, o_re, o_inc, o_hlt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
